// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 key-search scheduler: FSM states, S-RAM grant
// encoding and the default key width.
package arc4_pkg;

   localparam int unsigned KEY_W_DEF = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_INIT,
      ST_KSA,
      ST_PRGA,
      ST_FOUND,
      ST_FAIL,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      GR_INIT = 2'd0,
      GR_KSA  = 2'd1,
      GR_PRGA = 2'd2
   } grant_t;

   function automatic logic is_phase(input state_t s);
      return (s == ST_INIT) || (s == ST_KSA) || (s == ST_PRGA);
   endfunction

endpackage

// File: rtl/arc4_sched_mux.sv
// S-RAM port mux: forwards the granted requester's address, data and write
// enable; everything is forced to zero while gated off.
module s_mem_mux
   import arc4_pkg::*;
(
   input  grant_t          i_grant,
   input  logic            i_en,
   input  logic [2:0][7:0] i_req_addr,
   input  logic [2:0][7:0] i_req_wrdata,
   input  logic [2:0]      i_req_wren,
   output logic [7:0]      o_addr,
   output logic [7:0]      o_wrdata,
   output logic            o_wren
);

   always_comb begin
      o_addr   = '0;
      o_wrdata = '0;
      o_wren   = 1'b0;
      if (i_en) begin
         case (i_grant)
            GR_INIT: begin
               o_addr   = i_req_addr[0];
               o_wrdata = i_req_wrdata[0];
               o_wren   = i_req_wren[0];
            end
            GR_KSA: begin
               o_addr   = i_req_addr[1];
               o_wrdata = i_req_wrdata[1];
               o_wren   = i_req_wren[1];
            end
            GR_PRGA: begin
               o_addr   = i_req_addr[2];
               o_wrdata = i_req_wrdata[2];
               o_wren   = i_req_wren[2];
            end
            default: begin
               o_addr   = '0;
               o_wrdata = '0;
               o_wren   = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 key-search scheduler: steps each candidate key through the init, KSA
// and PRGA loop blocks, owns the S-RAM grant and a per-phase watchdog.
module arc4_sched
   import arc4_pkg::*;
#(
   parameter int unsigned KEY_W   = KEY_W_DEF,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KEY_W-1:0] key_lo,
   input  logic [KEY_W-1:0] key_hi,
   output logic [KEY_W-1:0] key,
   output logic             phase_clr,
   output logic             init_go,
   output logic             ksa_go,
   output logic             prga_go,
   input  logic             init_done,
   input  logic             ksa_done,
   input  logic             prga_done,
   input  logic             prga_ok,
   input  logic [2:0][7:0]  req_addr,
   input  logic [2:0][7:0]  req_wrdata,
   input  logic [2:0]       req_wren,
   output logic [7:0]       s_addr,
   output logic [7:0]       s_wrdata,
   output logic             s_wren,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             err
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t           r_state;
   grant_t           r_grant;
   logic [KEY_W-1:0] r_key;
   logic [KEY_W-1:0] r_key_hi;
   logic [WD_W-1:0]  r_wdog;
   logic             r_phase_clr;
   logic             r_init_go;
   logic             r_ksa_go;
   logic             r_prga_go;
   logic             r_busy;
   logic             r_done;
   logic             r_found;
   logic             r_err;

   logic             w_ph_done;
   logic             w_wd_exp;
   logic             w_mux_en;

   // Only the current phase's done counts; stray dones from other blocks are dropped.
   always_comb begin
      w_ph_done = 1'b0;
      case (r_state)
         ST_INIT: w_ph_done = init_done;
         ST_KSA:  w_ph_done = ksa_done;
         ST_PRGA: w_ph_done = prga_done;
         default: w_ph_done = 1'b0;
      endcase
   end

   assign w_wd_exp = (r_wdog == WD_LAST);
   assign w_mux_en = is_phase(r_state);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= GR_INIT;
         r_key       <= '0;
         r_key_hi    <= '0;
         r_wdog      <= '0;
         r_phase_clr <= 1'b0;
         r_init_go   <= 1'b0;
         r_ksa_go    <= 1'b0;
         r_prga_go   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_found     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_phase_clr <= 1'b0;
         case (r_state)
            ST_IDLE, ST_FOUND, ST_FAIL, ST_ERR: begin
               if (start) begin
                  r_key    <= key_lo;
                  r_key_hi <= key_hi;
                  r_wdog   <= '0;
                  r_found  <= 1'b0;
                  r_err    <= 1'b0;
                  if (key_lo > key_hi) begin
                     r_state <= ST_FAIL;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= ST_CLR;
                     r_phase_clr <= 1'b1;
                     r_busy      <= 1'b1;
                     r_done      <= 1'b0;
                  end
               end
            end
            ST_CLR: begin
               r_wdog    <= '0;
               r_grant   <= GR_INIT;
               r_init_go <= 1'b1;
               r_state   <= ST_INIT;
            end
            ST_INIT, ST_KSA, ST_PRGA: begin
               // Done is checked before expiry so a last-cycle completion still advances.
               if (w_ph_done) begin
                  r_wdog    <= '0;
                  r_init_go <= 1'b0;
                  r_ksa_go  <= 1'b0;
                  r_prga_go <= 1'b0;
                  case (r_state)
                     ST_INIT: begin
                        r_ksa_go <= 1'b1;
                        r_grant  <= GR_KSA;
                        r_state  <= ST_KSA;
                     end
                     ST_KSA: begin
                        r_prga_go <= 1'b1;
                        r_grant   <= GR_PRGA;
                        r_state   <= ST_PRGA;
                     end
                     default: begin
                        if (prga_ok) begin
                           r_state <= ST_FOUND;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_found <= 1'b1;
                        end else if (r_key == r_key_hi) begin
                           r_state <= ST_FAIL;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end else begin
                           r_key       <= r_key + KEY_W'(1);
                           r_phase_clr <= 1'b1;
                           r_state     <= ST_CLR;
                        end
                     end
                  endcase
               end else if (w_wd_exp) begin
                  r_wdog    <= '0;
                  r_init_go <= 1'b0;
                  r_ksa_go  <= 1'b0;
                  r_prga_go <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_state   <= ST_ERR;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   s_mem_mux u_mux (
      .i_grant      (r_grant),
      .i_en         (w_mux_en),
      .i_req_addr   (req_addr),
      .i_req_wrdata (req_wrdata),
      .i_req_wren   (req_wren),
      .o_addr       (s_addr),
      .o_wrdata     (s_wrdata),
      .o_wren       (s_wren)
   );

   assign key       = r_key;
   assign phase_clr = r_phase_clr;
   assign init_go   = r_init_go;
   assign ksa_go    = r_ksa_go;
   assign prga_go   = r_prga_go;
   assign busy      = r_busy;
   assign done      = r_done;
   assign found     = r_found;
   assign err       = r_err;

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: scripted loop-block responder, per-cycle mux checks and
// an outcome scoreboard filled from a reference search model.
module tb_arc4_sched;

   localparam int unsigned KW = 24;
   localparam int unsigned TO = 16;

   logic            clk = 1'b0;
   logic            rst, start;
   logic [KW-1:0]   key_lo, key_hi, key;
   logic            phase_clr, init_go, ksa_go, prga_go;
   logic            init_done, ksa_done, prga_done, prga_ok;
   logic [2:0][7:0] req_addr, req_wrdata;
   logic [2:0]      req_wren;
   logic [7:0]      s_addr, s_wrdata;
   logic            s_wren, busy, done, found, err;

   arc4_sched #(.KEY_W(KW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .key_lo(key_lo), .key_hi(key_hi),
      .key(key), .phase_clr(phase_clr), .init_go(init_go), .ksa_go(ksa_go),
      .prga_go(prga_go), .init_done(init_done), .ksa_done(ksa_done),
      .prga_done(prga_done), .prga_ok(prga_ok), .req_addr(req_addr),
      .req_wrdata(req_wrdata), .req_wren(req_wren), .s_addr(s_addr),
      .s_wrdata(s_wrdata), .s_wren(s_wren), .busy(busy), .done(done),
      .found(found), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   typedef struct {
      logic          found;
      logic          err;
      logic [KW-1:0] key;
      int            clrs;
   } exp_t;

   exp_t sb[$];

   int clr_cnt, init_cyc, go_cyc, lat;

   // Reference outcome: walk keys lo..hi, attempt number ok_att succeeds.
   function automatic exp_t model(input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                                  input int ok_att, input bit init_en);
      exp_t e;
      e.found = 1'b0; e.err = 1'b0; e.key = lo; e.clrs = 0;
      if (lo > hi) return e;
      if (!init_en) begin e.err = 1'b1; e.clrs = 1; return e; end
      for (longint k = longint'(lo); k <= longint'(hi); k++) begin
         e.clrs++;
         e.key = KW'(k);
         if (e.clrs == ok_att) begin e.found = 1'b1; return e; end
      end
      return e;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_found"}, found, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_clr"}, phase_clr, 0);
      chk({tag, "_gos"}, {init_go, ksa_go, prga_go}, 0);
      chk({tag, "_key"}, key, 0);
      chk({tag, "_s_wren"}, s_wren, 0);
      chk({tag, "_s_addr"}, s_addr, 0);
   endtask

   task automatic run(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input int ok_att,
                      input bit init_en, input bit poke, input bit abort);
      exp_t e;
      int   ph, last_ph, ph_cnt;
      bit   fin;
      if (!abort) sb.push_back(model(lo, hi, ok_att, init_en));
      @(negedge clk);
      key_lo = lo; key_hi = hi; start = 1'b1;
      clr_cnt = 0; init_cyc = 0; go_cyc = 0; lat = 0;
      last_ph = -1; ph_cnt = 0; fin = 1'b0;
      for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         key_lo = KW'($urandom); key_hi = KW'($urandom);
         req_addr   = 24'($urandom);
         req_wrdata = 24'($urandom);
         req_wren   = 3'($urandom);
         ph = init_go ? 1 : ksa_go ? 2 : prga_go ? 3 : 0;
         if (ph == 2) req_wren = 3'b111;
         #1;
         chk("go_onehot", ($countones({init_go, ksa_go, prga_go}) <= 1), 1);
         if (ph != 0) begin
            chk("s_addr", s_addr, req_addr[ph-1]);
            chk("s_wrdata", s_wrdata, req_wrdata[ph-1]);
            chk("s_wren", s_wren, req_wren[ph-1]);
         end else begin
            chk("s_addr_idle", s_addr, 0);
            chk("s_wren_idle", s_wren, 0);
         end
         if (phase_clr) clr_cnt++;
         if (init_go) init_cyc++;
         if (ph != 0) go_cyc++;
         if (done) begin fin = 1'b1; lat = cyc; end
         if (abort && ph == 2 && ph_cnt == 0 && last_ph == 2) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            check_reset_outputs("mid_rst");
            rst = 1'b0;
            return;
         end
         if (ph != last_ph) ph_cnt = 0; else ph_cnt++;
         last_ph = ph;
         init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0; prga_ok = 1'b0;
         case (ph)
            1: begin
               ksa_done  = (ph_cnt == 0);
               prga_done = (ph_cnt == 0);
               init_done = init_en && (ph_cnt == 2);
            end
            2: begin
               init_done = (ph_cnt == 0);
               ksa_done  = (ph_cnt == 1);
               if (poke) begin start = 1'b1; key_lo = '0; key_hi = '1; end
               if (abort) ph_cnt = -1;
            end
            3: begin
               prga_done = (ph_cnt == 2);
               prga_ok   = prga_done && (clr_cnt == ok_att);
            end
            default: ;
         endcase
      end
      init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0; prga_ok = 1'b0;
      if (!fin) chk("done_wait_expired", 0, 1);
      if (!abort) begin
         e = sb.pop_front();
         chk("found", found, e.found);
         chk("err", err, e.err);
         chk("done", done, 1);
         chk("busy", busy, 0);
         chk("key", key, e.key);
         chk("clr_pulses", clr_cnt, e.clrs);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; key_lo = '0; key_hi = '0;
      init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0; prga_ok = 1'b0;
      req_addr = '0; req_wrdata = '0; req_wren = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      run(24'd5, 24'd7, 2, 1'b1, 1'b1, 1'b0);

      run(24'hFFFFFF, 24'hFFFFFF, 0, 1'b1, 1'b0, 1'b0);

      run(24'd9, 24'd3, 0, 1'b1, 1'b0, 1'b0);
      chk("bad_range_latency", lat, 1);
      chk("bad_range_no_go", go_cyc, 0);

      run(24'd1, 24'd2, 0, 1'b0, 1'b0, 1'b0);
      chk("wd_init_cycles", init_cyc, TO);
      chk("wd_s_wren", s_wren, 0);

      run(24'd1, 24'd10, 0, 1'b1, 1'b0, 1'b1);

      run(24'd0, 24'd3, 4, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arc4_sched.md
ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 Parameter KEY_W, default 24, key width in bits.
REQ-002 Parameter TIMEOUT, default 4096, maximum cycles allowed per phase.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle pulse that begins a key search; sampled only in IDLE, FOUND, FAIL and ERR.
REQ-006 key_lo / key_hi  in  KEY_W each  first and last key to try, inclusive; latched on an accepted start.
REQ-007 key  out  KEY_W  current candidate key; after FOUND it holds the matching key.
REQ-008 phase_clr  out  1  one-cycle pulse that re-arms the init, KSA and PRGA loop blocks before each attempt.
REQ-009 init_go / ksa_go / prga_go  out  1 each  phase enables, held high for the whole phase.
REQ-010 init_done / ksa_done / prga_done  in  1 each  phase completion levels from the loop blocks.
REQ-011 prga_ok  in  1  decrypted-text-valid flag, sampled in the same cycle as prga_done.
REQ-012 req_addr  in  3x8  S-RAM address from each requester (0=init, 1=KSA, 2=PRGA).
REQ-013 req_wrdata  in  3x8  write data from each requester.
REQ-014 req_wren  in  3  write enable from each requester.
REQ-015 s_addr / s_wrdata  out  8 each  muxed S-RAM address and write data.
REQ-016 s_wren  out  1  muxed S-RAM write enable.
REQ-017 busy / done / found / err  out  1 each  status outputs.

Function
REQ-018 The state machine SHALL use the states IDLE, CLR, INIT, KSA, PRGA, FOUND, FAIL and ERR.
REQ-019 IDLE: on start, latch key_lo into key and key_hi into an internal register; go to CLR, or go directly to FAIL if key_lo > key_hi.
REQ-020 CLR: assert phase_clr for exactly one cycle, clear the watchdog, then go to INIT.
REQ-021 INIT: assert init_go with grant=0; go to KSA on init_done.
REQ-022 KSA: assert ksa_go with grant=1; go to PRGA on ksa_done.
REQ-023 PRGA: assert prga_go with grant=2; on prga_done:
- prga_ok=1 -> FOUND;
- otherwise, key == key_hi -> FAIL;
- otherwise key <= key+1 and go to CLR.
REQ-024 The key SHALL be compared before it is incremented, so key_hi = all-ones never wraps to zero.
REQ-025 A done input that belongs to a phase other than the current one SHALL be ignored.
REQ-026 The watchdog SHALL count the cycles spent in INIT, KSA or PRGA and reset on every phase transition; when it reaches TIMEOUT the block goes to ERR.
REQ-027 If a phase done and the watchdog expiry occur in the same cycle, the done SHALL win.
REQ-028 The memory mux SHALL be combinational from the registered grant: s_addr, s_wrdata and s_wren equal the granted requester's signals.
REQ-029 Outside INIT, KSA and PRGA, s_wren SHALL be 0 and s_addr SHALL be 0.
REQ-030 Write enables from requesters that do not hold the grant SHALL never reach s_wren.
REQ-031 busy SHALL be 1 in CLR, INIT, KSA and PRGA.
REQ-032 done SHALL be 1 in FOUND, FAIL and ERR; found SHALL be 1 only in FOUND; err SHALL be 1 only in ERR.
REQ-033 FOUND, FAIL and ERR SHALL hold until start, which restarts the search as in IDLE.
REQ-034 start while busy SHALL be ignored.
REQ-035 All go, clear and status outputs SHALL be registered, and each *_go SHALL be high in the first cycle of its state.

Reset
REQ-036 On rst=1 at a clock edge:
- state = IDLE, key = 0, internal key_hi register = 0, watchdog = 0, grant = 0;
- all go signals, phase_clr, busy, done, found and err = 0.
REQ-037 A reset in the middle of a phase SHALL abort the search, force s_wren to 0 on the following cycle, and issue no phase_clr.

Structure
REQ-038 Package arc4_pkg SHALL hold the state enum, the grant encoding (GR_INIT=0, GR_KSA=1, GR_PRGA=2) and the KEY_W default.
REQ-039 The memory mux SHALL be a sub-module named s_mem_mux (3 requesters, grant input, gating input).
REQ-040 The FSM, the key counter and the watchdog SHALL stay in arc4_sched.

Verification
REQ-041 key_lo=5, key_hi=7, prga_ok=1 on the second attempt -> found=1, key=6, two phase_clr pulses, busy then low.
REQ-042 key_lo=key_hi=24'hFFFFFF, prga_ok=0 -> FAIL after one attempt, key stays 24'hFFFFFF, found=0, done=1.
REQ-043 key_lo=9, key_hi=3 -> FAIL one cycle after start, no go signal asserted.
REQ-044 init_done never asserted with TIMEOUT=16 -> err=1 after 16 INIT cycles, s_wren=0.
REQ-045 req_wren=3'b111 in KSA -> s_wren and s_addr follow requester 1 only; ksa_done pulsed during INIT is ignored.
REQ-046 rst asserted mid-KSA -> IDLE next cycle, all outputs at reset values, s_wren=0.
